// File: rtl/typed_stream_arbiter_pkg.sv
// Shared types for the typed stream arbiter: element width of a stream and
// the arbiter FSM state, which is also exposed as a debug output.
package typed_stream_arbiter_pkg;
  typedef enum logic {BIT32 = 1'b0, BIT64 = 1'b1} type_width_t;
  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} arb_state_t;
endpackage

// File: rtl/typed_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI4S output between NUM_REQ typed streams.
// Define TYPED_ARB_PKT_CNT_EN to add per-requester packet counters (pkt_cnt, pkt_cnt_clr).
module typed_stream_arbiter
  import typed_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 8,
  parameter int REQ_IDX_W    = $clog2(NUM_REQ),
  localparam int AXI_WIDTH   = 64 * NUM_ELEMENTS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0][AXI_WIDTH-1:0]      in_tdata,
  input  logic [NUM_REQ-1:0][AXI_WIDTH/8-1:0]    in_tkeep,
  input  logic [NUM_REQ-1:0]                     in_tlast,
  input  logic [NUM_REQ-1:0]                     in_tvalid,
  output logic [NUM_REQ-1:0]                     in_tready,
  input  type_width_t [NUM_REQ-1:0]              in_type_width,
  output logic [AXI_WIDTH-1:0]                   out_tdata,
  output logic [AXI_WIDTH/8-1:0]                 out_tkeep,
  output logic                                   out_tlast,
  output logic                                   out_tvalid,
  input  logic                                   out_tready,
  output logic [REQ_IDX_W-1:0]                   out_tid,
  output type_width_t                            out_type_width,
`ifdef TYPED_ARB_PKT_CNT_EN
  input  logic                                   pkt_cnt_clr,
  output logic [NUM_REQ-1:0][31:0]               pkt_cnt,
`endif
  output arb_state_t                             dbg_state
);

  // Handshake: a beat moves when valid && ready on the same clk edge; a source
  // holds its beat until then. Only the granted requester ever sees ready.

  arb_state_t           state, state_nxt;
  logic [REQ_IDX_W-1:0] grant, rr_ptr, sel_idx;
  logic                 sel_found;
  type_width_t          tw_q;
  logic                 pkt_done;

  // First valid requester at or after rr_ptr; wrap by compare so non-power-of-two counts work.
  always_comb begin : rr_select
    logic [REQ_IDX_W-1:0] scan_idx;
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    scan_idx  = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && in_tvalid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
      scan_idx = (scan_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign pkt_done = (state == PASS) && in_tvalid[grant] && out_tready && in_tlast[grant];

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = PASS;
      default: if (pkt_done)  state_nxt = IDLE;
    endcase
  end

  always_comb begin : pass_through
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    in_tready  = '0;
    if (state == PASS) begin
      out_tdata        = in_tdata[grant];
      out_tkeep        = in_tkeep[grant];
      out_tlast        = in_tlast[grant];
      out_tvalid       = in_tvalid[grant];
      in_tready[grant] = out_tready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      tw_q   <= BIT32;
    end else begin
      state <= state_nxt;
      // Grant and type are captured once per packet and held until its last beat.
      if (state == IDLE && sel_found) begin
        grant <= sel_idx;
        tw_q  <= in_type_width[sel_idx];
      end
      if (pkt_done) rr_ptr <= (grant == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign out_tid        = grant;
  assign out_type_width = tw_q;
  assign dbg_state      = state;

`ifdef TYPED_ARB_PKT_CNT_EN
  // Clear has priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || pkt_cnt_clr) begin
      pkt_cnt <= '0;
    end else if (pkt_done) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_typed_stream_arbiter.sv
// Bench for typed_stream_arbiter: queued producer packets, a packet-level grant model
// and an expected-beat scoreboard, plus directed scenarios.
module tb_typed_stream_arbiter;
  import typed_stream_arbiter_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int NUM_ELEMENTS = 8;
  localparam int AXI_WIDTH    = 64 * NUM_ELEMENTS;
  localparam int KEEP_W       = AXI_WIDTH / 8;
  localparam int REQ_IDX_W    = $clog2(NUM_REQ);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0][AXI_WIDTH-1:0] in_tdata;
  logic [NUM_REQ-1:0][KEEP_W-1:0]    in_tkeep;
  logic [NUM_REQ-1:0]                in_tlast, in_tvalid, in_tready;
  type_width_t [NUM_REQ-1:0]         in_type_width;
  logic [AXI_WIDTH-1:0]              out_tdata;
  logic [KEEP_W-1:0]                 out_tkeep;
  logic                              out_tlast, out_tvalid, out_tready;
  logic [REQ_IDX_W-1:0]              out_tid;
  type_width_t                       out_type_width;
  arb_state_t                        dbg_state;
`ifdef TYPED_ARB_PKT_CNT_EN
  logic                              pkt_cnt_clr;
  logic [NUM_REQ-1:0][31:0]          pkt_cnt;
`endif

  typed_stream_arbiter #(.NUM_REQ(NUM_REQ), .NUM_ELEMENTS(NUM_ELEMENTS)) dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_type_width(in_type_width),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tid(out_tid),
    .out_type_width(out_type_width),
`ifdef TYPED_ARB_PKT_CNT_EN
    .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int n_checks, n_fail;
  logic [AXI_WIDTH:0] src_q [NUM_REQ][$];   // {last, data} beats per producer
  logic [AXI_WIDTH:0] exp_q [$];            // expected output beats, in order
  logic [NUM_REQ-1:0] hs_q, vld_hold, tw_toggle;
  int stall_cnt [NUM_REQ];
  int gap_pct, rdy_mode, tw_rand_pct;
  int m_owner, m_ptr;
  type_width_t m_type;
  int m_cnt [NUM_REQ];
  logic obs_hs, obs_vld, obs_last;
  logic [REQ_IDX_W-1:0] obs_tid;
  type_width_t obs_tw;
  logic [AXI_WIDTH-1:0] obs_data;
  int obs_owner;

  function automatic logic [KEEP_W-1:0] keep_pat(input int r);
    logic [KEEP_W-1:0] k;
    k = '1;
    return k >> r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_packet(input int r, input int len, input logic [31:0] base);
    logic [AXI_WIDTH:0] beat;
    for (int b = 0; b < len; b++) begin
      beat = '0;
      beat[31:0]  = base + 32'(b);
      beat[63:32] = $urandom();
      beat[AXI_WIDTH-1 -: 8] = 8'(r);
      beat[AXI_WIDTH] = (b == len - 1);
      src_q[r].push_back(beat);
    end
  endtask

  task automatic drive_update();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_q[i]) begin
        void'(src_q[i].pop_front());
        vld_hold[i] = 1'b0;
      end
      if (tw_toggle[i] || ($urandom_range(0, 99) < tw_rand_pct))
        in_type_width[i] = (in_type_width[i] == BIT32) ? BIT64 : BIT32;
      in_tkeep[i] = keep_pat(i);
      if (src_q[i].size() == 0) begin
        in_tvalid[i] = 1'b0;
        in_tlast[i]  = 1'b0;
        in_tdata[i]  = '0;
      end else begin
        in_tdata[i] = src_q[i][0][AXI_WIDTH-1:0];
        in_tlast[i] = src_q[i][0][AXI_WIDTH];
        if (stall_cnt[i] > 0) begin
          in_tvalid[i] = 1'b0;
          stall_cnt[i]--;
        end else if (vld_hold[i]) begin
          in_tvalid[i] = 1'b1;
        end else begin
          in_tvalid[i] = ($urandom_range(0, 99) >= gap_pct);
        end
        if (in_tvalid[i]) vld_hold[i] = 1'b1;
      end
    end
    hs_q = '0;
    case (rdy_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = 1'($urandom_range(0, 1));
      default: out_tready = ~out_tready;
    endcase
  endtask

  // ---------------- reference model + scoreboard ----------------
  task automatic model_step();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [AXI_WIDTH:0] e;
    logic last_exp;
    obs_hs = out_tvalid && out_tready;
    obs_vld = out_tvalid; obs_last = out_tlast; obs_tid = out_tid;
    obs_tw = out_type_width; obs_data = out_tdata; obs_owner = m_owner;
    for (int i = 0; i < NUM_REQ; i++) hs_q[i] = in_tvalid[i] && in_tready[i];
`ifdef TYPED_ARB_PKT_CNT_EN
    if (pkt_cnt_clr) for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
`endif
    if (m_owner < 0) begin
      n_checks++;
      if (out_tvalid !== 1'b0 || in_tready !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs: out_tvalid=%b in_tready=%b, required 0 and 0", out_tvalid, in_tready);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (m_owner < 0 && in_tvalid[j]) begin
          m_owner = j;
          m_type  = in_type_width[j];
          for (int b = 0; b < src_q[j].size(); b++) begin
            exp_q.push_back(src_q[j][b]);
            if (src_q[j][b][AXI_WIDTH]) break;
          end
        end
      end
    end else begin
      exp_rdy = '0;
      if (out_tready) exp_rdy[m_owner] = 1'b1;
      n_checks++;
      if (out_tid !== REQ_IDX_W'(m_owner)) begin
        n_fail++; $display("FAIL grant_tid: got %0d, required %0d", out_tid, m_owner);
      end
      n_checks++;
      if (out_type_width !== m_type) begin
        n_fail++; $display("FAIL type_width: got %0d, required %0d", out_type_width, m_type);
      end
      n_checks++;
      if (out_tvalid !== in_tvalid[m_owner] || in_tready !== exp_rdy) begin
        n_fail++;
        $display("FAIL pass_handshake: out_tvalid=%b in_tready=%b, required %b and %b",
                 out_tvalid, in_tready, in_tvalid[m_owner], exp_rdy);
      end
      if (out_tvalid && out_tready) begin
        last_exp = out_tlast;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_beat: data=%h, required no beat", out_tdata[63:0]);
        end else begin
          e = exp_q.pop_front();
          last_exp = e[AXI_WIDTH];
          if (out_tdata !== e[AXI_WIDTH-1:0] || out_tlast !== e[AXI_WIDTH] || out_tkeep !== keep_pat(m_owner)) begin
            n_fail++;
            $display("FAIL beat_data: got last=%b data=%h keep=%h, required last=%b data=%h keep=%h",
                     out_tlast, out_tdata[63:0], out_tkeep, e[AXI_WIDTH], e[63:0], keep_pat(m_owner));
          end
        end
        if (last_exp) begin
`ifdef TYPED_ARB_PKT_CNT_EN
          if (!pkt_cnt_clr) m_cnt[m_owner]++;
`endif
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end
    end
  endtask

  // One clock cycle: drive after the edge, sample 1 unit later, then advance.
  task automatic tick();
    drive_update();
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_tvalid = '0; in_tlast = '0; in_tdata = '0; out_tready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      stall_cnt[i] = 0;
      m_cnt[i] = 0;
      in_type_width[i] = BIT32;
    end
    exp_q.delete();
    hs_q = '0; vld_hold = '0; tw_toggle = '0;
    tw_rand_pct = 0; gap_pct = 0; rdy_mode = 0;
`ifdef TYPED_ARB_PKT_CNT_EN
    pkt_cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_owner = -1;
    m_ptr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_tvalid = '1; in_tlast = '0; out_tready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) in_type_width[i] = BIT64;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_tvalid !== 1'b0 || in_tready !== '0) begin
      n_fail++; $display("FAIL reset_valid_ready: out_tvalid=%b in_tready=%b, required 0 and 0", out_tvalid, in_tready);
    end
    n_checks++;
    if (out_tid !== '0 || out_type_width !== BIT32) begin
      n_fail++; $display("FAIL reset_tid_type: tid=%0d type=%0d, required 0 and BIT32", out_tid, out_type_width);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int n_hs, first_c;
    apply_reset();
    in_type_width[1] = BIT64;
    push_packet(1, 3, 32'hA0);
    n_hs = 0; first_c = -1;
    for (int c = 0; c < 20 && n_hs < 3; c++) begin
      tick();
      if (obs_hs) begin
        if (n_hs == 0) first_c = c;
        n_checks++;
        if (obs_tid !== REQ_IDX_W'(1) || obs_tw !== BIT64) begin
          n_fail++; $display("FAIL single_tid_type: tid=%0d type=%0d, required 1 and BIT64", obs_tid, obs_tw);
        end
        n_checks++;
        if (obs_data[31:0] !== 32'(32'hA0 + n_hs)) begin
          n_fail++; $display("FAIL single_data: got %h, required %h", obs_data[31:0], 32'hA0 + n_hs);
        end
        n_hs++;
      end
    end
    n_checks++;
    if (n_hs != 3 || first_c != 1) begin
      n_fail++; $display("FAIL single_latency: beats=%0d first_cycle=%0d, required 3 and 1", n_hs, first_c);
    end
    n_checks++;
    if (dbg_state !== IDLE || out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL single_back_idle: state=%0d out_tvalid=%b, required IDLE and 0", dbg_state, out_tvalid);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    int k, last_end;
    bit in_pkt;
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) push_packet(i, 2, 32'h100 * (i + 1));
    push_packet(0, 2, 32'h500);
    k = 0; last_end = 0; in_pkt = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      tick();
      if (obs_hs) begin
        if (!in_pkt) begin
          n_checks++;
          if (obs_tid !== REQ_IDX_W'(exp_order[k])) begin
            n_fail++; $display("FAIL rr_order: packet %0d tid=%0d, required %0d", k, obs_tid, exp_order[k]);
          end
          if (k > 0) begin
            n_checks++;
            if (c - last_end != 2) begin
              n_fail++; $display("FAIL rr_bubble: gap=%0d cycles, required 2", c - last_end);
            end
          end
          in_pkt = 1;
        end
        if (obs_last) begin
          in_pkt = 0; last_end = c; k++;
        end
      end
    end
    n_checks++;
    if (k != 5) begin
      n_fail++; $display("FAIL rr_timeout: packets=%0d, required 5", k);
    end
  endtask

  task automatic test_grant_lock();
    int n0, gap;
    bit done;
    apply_reset();
    push_packet(0, 4, 32'h200);
    push_packet(2, 2, 32'h300);
    n0 = 0; gap = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      if (obs_owner == 0 && !obs_vld) begin
        gap++;
        n_checks++;
        if (obs_tid !== '0) begin
          n_fail++; $display("FAIL lock_tid: got %0d during stall, required 0", obs_tid);
        end
      end
      if (obs_hs) begin
        if (obs_tid == '0) begin
          n0++;
          if (n0 == 2) stall_cnt[0] = 5;
        end else begin
          n_checks++;
          if (n0 != 4) begin
            n_fail++; $display("FAIL lock_order: req2 beat after %0d req0 beats, required 4", n0);
          end
          if (obs_last) done = 1;
        end
      end
    end
    n_checks++;
    if (gap != 5 || n0 != 4 || !done) begin
      n_fail++; $display("FAIL lock_summary: stall=%0d req0_beats=%0d done=%0d, required 5 4 1", gap, n0, done);
    end
  endtask

  task automatic test_type_switch();
    int n3, n1;
    apply_reset();
    in_type_width[3] = BIT32;
    in_type_width[1] = BIT64;
    push_packet(3, 4, 32'h400);
    n3 = 0; n1 = 0;
    for (int c = 0; c < 60 && n1 < 2; c++) begin
      tick();
      if (obs_hs && obs_tid == REQ_IDX_W'(3)) begin
        n3++;
        n_checks++;
        if (obs_tw !== BIT32) begin
          n_fail++; $display("FAIL type_hold_req3: got %0d, required BIT32", obs_tw);
        end
        if (n3 == 1) begin
          tw_toggle[3] = 1'b1;
          push_packet(1, 2, 32'h600);
        end
        if (obs_last) begin
          tw_toggle[3] = 1'b0;
          in_type_width[3] = BIT32;
        end
      end else if (obs_hs && obs_tid == REQ_IDX_W'(1)) begin
        n1++;
        n_checks++;
        if (obs_tw !== BIT64) begin
          n_fail++; $display("FAIL type_next_req1: got %0d, required BIT64", obs_tw);
        end
      end
    end
    n_checks++;
    if (n3 != 4 || n1 != 2) begin
      n_fail++; $display("FAIL type_timeout: req3=%0d req1=%0d beats, required 4 and 2", n3, n1);
    end
  endtask

  task automatic test_backpressure_reset();
    int n;
    apply_reset();
    rdy_mode = 2;
    out_tready = 1'b1;
    push_packet(2, 8, 32'h700);
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick();
      if (obs_hs) begin
        n_checks++;
        if (obs_tid !== REQ_IDX_W'(2) || obs_data[31:0] !== 32'(32'h700 + n)) begin
          n_fail++; $display("FAIL bp_beat: tid=%0d data=%h, required 2 and %h", obs_tid, obs_data[31:0], 32'h700 + n);
        end
        n++;
      end
    end
    n_checks++;
    if (n != 8) begin
      n_fail++; $display("FAIL bp_count: beats=%0d, required 8", n);
    end
    rdy_mode = 0;
    in_type_width[1] = BIT64;
    push_packet(1, 8, 32'h800);
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (obs_hs) n++;
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL mid_reset_setup: beats=%0d, required 3", n);
    end
    rst = 1'b1;
    drive_update();
    #1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_tvalid !== 1'b0 || in_tready !== '0 || out_tid !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: out_tvalid=%b in_tready=%b tid=%0d, required 0 0 0", out_tvalid, in_tready, out_tid);
    end
    n_checks++;
    if (dbg_state !== IDLE || out_type_width !== BIT32) begin
      n_fail++; $display("FAIL mid_reset_state: state=%0d type=%0d, required IDLE and BIT32", dbg_state, out_type_width);
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic [31:0] seq;
    bit busy;
    apply_reset();
    gap_pct = 30; rdy_mode = 1; tw_rand_pct = 5;
    seq = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() < 6 && $urandom_range(0, 7) == 0) begin
          push_packet(i, $urandom_range(1, 5), seq);
          seq = seq + 32'h10;
        end
      end
      tick();
    end
    gap_pct = 0; rdy_mode = 0; tw_rand_pct = 0;
    busy = 1;
    for (int c = 0; c < 400 && busy; c++) begin
      tick();
      busy = (m_owner >= 0);
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) busy = 1;
    end
    n_checks++;
    if (busy || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: pending=%0d expected beats left=%0d, required 0 0", busy, exp_q.size());
    end
`ifdef TYPED_ARB_PKT_CNT_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      n_checks++;
      if (pkt_cnt[i] !== 32'(m_cnt[i])) begin
        n_fail++; $display("FAIL random_pkt_cnt[%0d]: got %0d, required %0d", i, pkt_cnt[i], m_cnt[i]);
      end
    end
`endif
  endtask

`ifdef TYPED_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    apply_reset();
    for (int p = 0; p < 3; p++) push_packet(2, 2, 32'h900 + 32'(p * 16));
    for (int c = 0; c < 40 && (src_q[2].size() != 0 || m_owner >= 0); c++) tick();
    n_checks++;
    if (pkt_cnt[2] !== 32'd3 || pkt_cnt[0] !== 32'd0) begin
      n_fail++; $display("FAIL pkt_cnt_three: cnt2=%0d cnt0=%0d, required 3 and 0", pkt_cnt[2], pkt_cnt[0]);
    end
    push_packet(2, 1, 32'h9F0);
    tick();
    pkt_cnt_clr = 1'b1;
    tick();
    pkt_cnt_clr = 1'b0;
    n_checks++;
    if (!(obs_hs && obs_last) || pkt_cnt[2] !== 32'd0) begin
      n_fail++; $display("FAIL pkt_cnt_clear_wins: hs=%b cnt2=%0d, required 1 and 0", obs_hs && obs_last, pkt_cnt[2]);
    end
    push_packet(2, 1, 32'h9F8);
    for (int c = 0; c < 20 && (src_q[2].size() != 0 || m_owner >= 0); c++) tick();
    n_checks++;
    if (pkt_cnt[2] !== 32'd1) begin
      n_fail++; $display("FAIL pkt_cnt_after_clear: got %0d, required 1", pkt_cnt[2]);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    out_tready = 1'b1; rst = 1'b1;
    in_tdata = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
    hs_q = '0; vld_hold = '0; tw_toggle = '0;
    gap_pct = 0; rdy_mode = 0; tw_rand_pct = 0; m_owner = -1; m_ptr = 0; m_type = BIT32;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_type_width[i] = BIT32; stall_cnt[i] = 0; m_cnt[i] = 0;
    end
`ifdef TYPED_ARB_PKT_CNT_EN
    pkt_cnt_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_grant_lock();
    test_type_switch();
    test_backpressure_reset();
    test_random();
`ifdef TYPED_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
